// File: rtl/div_pkg.sv
// Shared definitions for the divider issue sequencer: widths, timeout and
// the sequencer state encoding.
package div_pkg;

    localparam int DIV_W           = 16;
    localparam int DIV_TIMEOUT_CYC = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_PRE   = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_HOLD  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_LOAD  = ST_LOAD,
        S_PRE   = ST_PRE,
        S_RUN   = ST_RUN,
        S_HOLD  = ST_HOLD
    } div_state_e;

endpackage

// File: rtl/div_seq_timer.sv
// RUN-state watchdog: clearable up-counter with a terminal-count flag
// that marks the last cycle the divider is allowed to take.
module div_seq_timer #(
    parameter int TW = 7,
    parameter int TC = 63
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [TW-1:0] r_cnt;

    // Count RUN cycles; clear takes priority over enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == TW'(TC));

endmodule

// File: rtl/div_sequencer.sv
// Issue-side sequencer feeding the divider control FSM: operand capture,
// start/goreq/count_done ordering, result hold with timeout reporting.
// Optional macro DIV_ZERO_BYPASS_EN: zero divisor skips the divider.
module div_sequencer
    import div_pkg::*;
#(
    parameter int W           = DIV_W,
    parameter int TIMEOUT_CYC = DIV_TIMEOUT_CYC,
    parameter int TW          = $clog2(TIMEOUT_CYC) + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] opa_q,
    output logic [W-1:0] opb_q,
    output logic         start,
    output logic         goreq,
    output logic         count_done,
    input  logic         rem_ge,
    input  logic         done_in,
    input  logic [W-1:0] quotient_in,
    input  logic [W-1:0] remainder_in,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         timeout_err,
    output logic         div_by_zero
);

    div_state_e   r_state;
    logic         r_op_ready;
    logic         r_start;
    logic         r_goreq;
    logic         r_count_done;
    logic         r_res_valid;
    logic         r_timeout;
    logic [W-1:0] r_opa;
    logic [W-1:0] r_opb;
    logic [W-1:0] r_quot;
    logic [W-1:0] r_rem;
`ifdef DIV_ZERO_BYPASS_EN
    logic         r_dbz;
`endif

    logic w_clr;
    logic w_en;
    logic w_tc;

    assign w_clr = (r_state == S_PRE);
    assign w_en  = (r_state == S_RUN);

    div_seq_timer #(
        .TW (TW),
        .TC (TIMEOUT_CYC - 1)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_tc    (w_tc)
    );

    // Sequencer FSM: every control strobe is registered one state ahead.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_op_ready   <= 1'b1;
            r_start      <= 1'b0;
            r_goreq      <= 1'b0;
            r_count_done <= 1'b0;
            r_res_valid  <= 1'b0;
            r_timeout    <= 1'b0;
            r_opa        <= '0;
            r_opb        <= '0;
            r_quot       <= '0;
            r_rem        <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            r_dbz        <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_opa      <= dividend;
                        r_opb      <= divisor;
                        r_op_ready <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
                        if (divisor == '0) begin
                            r_quot      <= '1;
                            r_rem       <= dividend;
                            r_timeout   <= 1'b0;
                            r_dbz       <= 1'b1;
                            r_res_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= S_START;
                        end
`else
                        r_start <= 1'b1;
                        r_state <= S_START;
`endif
                    end
                end
                S_START: begin
                    r_start <= 1'b0;
                    r_goreq <= 1'b1;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_goreq      <= 1'b0;
                    r_count_done <= 1'b1;
                    r_state      <= S_PRE;
                end
                S_PRE: begin
                    r_count_done <= 1'b0;
                    r_state      <= S_RUN;
                end
                S_RUN: begin
                    // A done on the terminal cycle still wins over timeout.
                    if (done_in) begin
                        r_quot      <= quotient_in;
                        r_rem       <= remainder_in;
                        r_timeout   <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else if (w_tc) begin
                        r_quot      <= '0;
                        r_rem       <= '0;
                        r_timeout   <= 1'b1;
                        r_res_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_timeout   <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
                        r_dbz       <= 1'b0;
`endif
                        r_op_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign op_ready    = r_op_ready;
    assign opa_q       = r_opa;
    assign opb_q       = r_opb;
    assign start       = r_start;
    assign goreq       = (r_state == S_RUN) ? rem_ge : r_goreq;
    assign count_done  = r_count_done;
    assign res_valid   = r_res_valid;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign timeout_err = r_timeout;
`ifdef DIV_ZERO_BYPASS_EN
    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer with a behavioural divider control/datapath model
// and a result scoreboard.
module tb_div_sequencer;
    import div_pkg::*;

    localparam int W       = DIV_W;
    localparam int RUN_LEN = 17;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         op_valid = 1'b0;
    logic         op_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] opa_q;
    logic [W-1:0] opb_q;
    logic         start;
    logic         goreq;
    logic         count_done;
    logic         rem_ge = 1'b0;
    logic         done_in = 1'b0;
    logic [W-1:0] quotient_in = '0;
    logic [W-1:0] remainder_in = '0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         timeout_err;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         to;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    div_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .dividend     (dividend),
        .divisor      (divisor),
        .opa_q        (opa_q),
        .opb_q        (opb_q),
        .start        (start),
        .goreq        (goreq),
        .count_done   (count_done),
        .rem_ge       (rem_ge),
        .done_in      (done_in),
        .quotient_in  (quotient_in),
        .remainder_in (remainder_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .quotient     (quotient),
        .remainder    (remainder),
        .timeout_err  (timeout_err),
        .div_by_zero  (div_by_zero)
    );

    // Divider control model: idle/err -> c1 -> c2 -> run -> done pulse
    int mst = 0;
    int mcnt = 0;
    bit hang = 1'b0;

    always @(posedge clk) begin
        rem_ge <= 1'($urandom);
        if (!reset_n) begin
            mst     <= 0;
            done_in <= 1'b0;
        end else if (start) begin
            mst     <= 1;
            done_in <= 1'b0;
        end else if (done_in) begin
            mst     <= 0;
            done_in <= 1'b0;
        end else if (mst == 1 && goreq) begin
            mst <= 2;
        end else if (mst == 2 && count_done) begin
            mst  <= 3;
            mcnt <= 0;
        end else if (mst == 3) begin
            mcnt <= mcnt + 1;
            if (mcnt == RUN_LEN - 1 && !hang) begin
                done_in <= 1'b1;
                if (opb_q == '0) begin
                    quotient_in  <= '1;
                    remainder_in <= opa_q;
                end else begin
                    quotient_in  <= opa_q / opb_q;
                    remainder_in <= opa_q % opb_q;
                end
            end
        end
    end

    // Strobe monitor
    int cyc = 0;
    int start_cnt = 0;
    int gq_cnt = 0;
    int cd_cnt = 0;
    int start_cyc = -1;
    int gq_cyc = -1;
    int cd_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
        if (goreq && mst == 1) begin
            gq_cnt = gq_cnt + 1;
            gq_cyc = cyc;
        end
        if (count_done) begin
            cd_cnt = cd_cnt + 1;
            cd_cyc = cyc;
        end
    end

    task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_res(output bit ok, output int run_cyc,
                            output int fwd_bad);
        ok = 1'b0;
        run_cyc = 0;
        fwd_bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            if (mst == 3) begin
                run_cyc++;
                if (goreq !== rem_ge) fwd_bad++;
            end
        end
    endtask

    task automatic accept();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (op_ready !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL reset_hs ready=%b valid=%b want 1/0",
                     op_ready, res_valid);
        if (op_ready !== 1'b1 || res_valid !== 1'b0) errors++;
        checks++;
        if ({start, goreq, count_done, timeout_err, div_by_zero} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 00000",
                     {start, goreq, count_done, timeout_err, div_by_zero});
        end
        checks++;
        if ({opa_q, opb_q, quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_regs opa=%h opb=%h q=%h r=%h want 0",
                     opa_q, opb_q, quotient, remainder);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int s, g, c, rc, fb;
        bit ok;
        exp_t e, got;
        s = start_cnt;
        g = gq_cnt;
        c = cd_cnt;
        send_op(16'd100, 16'd7);
        sb.push_back('{q: 16'd14, r: 16'd2, to: 1'b0, dz: 1'b0});
        wait_res(ok, rc, fb);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_wait res_valid=%b want 1", res_valid);
        end
        e = sb.pop_front();
        got = '{q: quotient, r: remainder, to: timeout_err, dz: div_by_zero};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL basic_res got q=%0d r=%0d to=%b dz=%b want q=%0d r=%0d to=%b dz=%b",
                     got.q, got.r, got.to, got.dz, e.q, e.r, e.to, e.dz);
        end
        checks++;
        if (start_cnt - s != 1 || gq_cnt - g != 1 || cd_cnt - c != 1) begin
            errors++;
            $display("FAIL basic_strobes got start=%0d goreq=%0d cd=%0d want 1 1 1",
                     start_cnt - s, gq_cnt - g, cd_cnt - c);
        end
        checks++;
        if (gq_cyc != start_cyc + 1 || cd_cyc != start_cyc + 2) begin
            errors++;
            $display("FAIL basic_order got start@%0d goreq@%0d cd@%0d want consecutive",
                     start_cyc, gq_cyc, cd_cyc);
        end
        checks++;
        if (fb != 0) begin
            errors++;
            $display("FAIL basic_fwd got %0d goreq/rem_ge mismatches want 0", fb);
        end
        checks++;
        if (rc != RUN_LEN + 1) begin
            errors++;
            $display("FAIL basic_runlen got %0d want %0d", rc, RUN_LEN + 1);
        end
        accept();
    endtask

    task automatic test_hold();
        int rc, fb, bad;
        bit ok;
        exp_t e, got;
        send_op(16'hFFFF, 16'd1);
        sb.push_back('{q: 16'hFFFF, r: 16'd0, to: 1'b0, dz: 1'b0});
        wait_res(ok, rc, fb);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_wait res_valid=%b want 1", res_valid);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op_valid = (i < 5);
            dividend = 16'd1234;
            divisor  = 16'd5;
            if (res_valid !== 1'b1 || op_ready !== 1'b0 ||
                quotient !== 16'hFFFF || remainder !== 16'd0 ||
                opa_q !== 16'hFFFF)
                bad++;
        end
        op_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable got %0d bad cycles want 0", bad);
        end
        e = sb.pop_front();
        got = '{q: quotient, r: remainder, to: timeout_err, dz: div_by_zero};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL hold_res got q=%h r=%h want q=%h r=%h",
                     got.q, got.r, e.q, e.r);
        end
        accept();
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release ready=%b valid=%b want 1/0",
                     op_ready, res_valid);
        end
    endtask

    task automatic test_timeout();
        int rc, fb;
        bit ok;
        exp_t e, got;
        hang = 1'b1;
        send_op(16'd1, 16'd1);
        sb.push_back('{q: 16'd0, r: 16'd0, to: 1'b1, dz: 1'b0});
        wait_res(ok, rc, fb);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL to_wait res_valid=%b want 1", res_valid);
        end
        checks++;
        if (rc != DIV_TIMEOUT_CYC) begin
            errors++;
            $display("FAIL to_cycles got %0d want %0d", rc, DIV_TIMEOUT_CYC);
        end
        e = sb.pop_front();
        got = '{q: quotient, r: remainder, to: timeout_err, dz: div_by_zero};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL to_res got q=%h r=%h to=%b want q=%h r=%h to=%b",
                     got.q, got.r, got.to, e.q, e.r, e.to);
        end
        accept();
        hang = 1'b0;
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL to_clear got %b want 0", timeout_err);
        end
        send_op(16'd9, 16'd3);
        sb.push_back('{q: 16'd3, r: 16'd0, to: 1'b0, dz: 1'b0});
        wait_res(ok, rc, fb);
        e = sb.pop_front();
        got = '{q: quotient, r: remainder, to: timeout_err, dz: div_by_zero};
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL to_recover got ok=%b q=%0d r=%0d to=%b want q=%0d r=%0d to=%b",
                     ok, got.q, got.r, got.to, e.q, e.r, e.to);
        end
        accept();
    endtask

    task automatic test_div_zero();
        int s, rc, fb, want_starts;
        bit ok;
        exp_t e, got;
        s = start_cnt;
        send_op(16'd5, 16'd0);
`ifdef DIV_ZERO_BYPASS_EN
        sb.push_back('{q: 16'hFFFF, r: 16'd5, to: 1'b0, dz: 1'b1});
        want_starts = 0;
`else
        sb.push_back('{q: 16'hFFFF, r: 16'd5, to: 1'b0, dz: 1'b0});
        want_starts = 1;
`endif
        wait_res(ok, rc, fb);
        e = sb.pop_front();
        got = '{q: quotient, r: remainder, to: timeout_err, dz: div_by_zero};
        checks++;
        if (!ok || got !== e) begin
            errors++;
            $display("FAIL dz_res got ok=%b q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                     ok, got.q, got.r, got.dz, e.q, e.r, e.dz);
        end
        checks++;
        if (start_cnt - s != want_starts) begin
            errors++;
            $display("FAIL dz_start got %0d pulses want %0d",
                     start_cnt - s, want_starts);
        end
        accept();
        @(negedge clk);
        checks++;
        if (div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL dz_clear got %b want 0", div_by_zero);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        int late;
        send_op(16'd200, 16'd9);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mst == 3) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mr_enter_run got mst=%0d want 3", mst);
        end
        repeat (3) @(negedge clk);
        op_valid = 1'b1;
        dividend = 16'd77;
        divisor  = 16'd3;
        repeat (2) @(negedge clk);
        op_valid = 1'b0;
        checks++;
        if (opa_q !== 16'd200 || opb_q !== 16'd9 || op_ready !== 1'b0) begin
            errors++;
            $display("FAIL mr_no_capture got opa=%0d opb=%0d rdy=%b want 200 9 0",
                     opa_q, opb_q, op_ready);
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++;
        if (op_ready !== 1'b1 || res_valid !== 1'b0 || opa_q !== '0) begin
            errors++;
            $display("FAIL mr_abort got rdy=%b valid=%b opa=%0d want 1 0 0",
                     op_ready, res_valid, opa_q);
        end
        late = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid || start) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL mr_quiet got %0d active cycles want 0", late);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        int rc, fb;
        bit ok;
        exp_t e, got;
        for (int n = 0; n < 6; n++) begin
            a = W'($urandom);
            b = W'($urandom_range(1, 65535));
            if (n == 0) b = 16'hFFFF;
            send_op(a, b);
            sb.push_back('{q: a / b, r: a % b, to: 1'b0, dz: 1'b0});
            wait_res(ok, rc, fb);
            e = sb.pop_front();
            got = '{q: quotient, r: remainder, to: timeout_err, dz: div_by_zero};
            checks++;
            if (!ok || got !== e || fb != 0) begin
                errors++;
                $display("FAIL b2b_%0d got ok=%b q=%h r=%h fwd=%0d want q=%h r=%h",
                         n, ok, got.q, got.r, fb, e.q, e.r);
            end
            accept();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_timeout();
        test_div_zero();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
